// File: rtl/mem_stage_pkg.sv
// Shared decode constants, NOP encoding and the memory-stage FSM state type.
package mem_stage_pkg;

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;

  localparam logic [2:0]  F3_B      = 3'b000;
  localparam logic [2:0]  F3_H      = 3'b001;
  localparam logic [2:0]  F3_W      = 3'b010;
  localparam logic [2:0]  F3_BU     = 3'b100;
  localparam logic [2:0]  F3_HU     = 3'b101;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic {IDLE, WAIT} mem_state_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load formatter: picks the addressed lane and sign/zero-extends it.
module load_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [15:0] lane;

  assign lane = 16'(dmem_rdata >> {addr, 3'b000});

  always_comb begin
    result = dmem_rdata;
    case (funct3)
      F3_B:    result = {{(XLEN-8){lane[7]}}, lane[7:0]};
      F3_BU:   result = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3_H:    result = {{(XLEN-16){lane[15]}}, lane};
      F3_HU:   result = {{(XLEN-16){1'b0}}, lane};
      default: result = dmem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: drives data-memory req/ack accesses, stalls upstream
// while an access is outstanding, and loads the MEM/WB registers.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [XLEN-1:0]           pc_mem,
  input  logic [XLEN-1:0]           alu_mem,
  input  logic [XLEN-1:0]           rs2_mem,
  input  logic [XLEN-1:0]           instr_mem,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_mem,
  output logic [XLEN-1:0]           forward_mem,
  output logic                      stall_mem,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [XLEN-1:0]           dmem_addr,
  output logic [3:0]                dmem_be,
  output logic [XLEN-1:0]           dmem_wdata,
  input  logic                      dmem_ack,
  input  logic [XLEN-1:0]           dmem_rdata,
  output logic [XLEN-1:0]           pc_wb,
  output logic [XLEN-1:0]           result_wb,
  output logic [XLEN-1:0]           instr_wb,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_wb,
  output logic                      misalign_wb,
  output logic                      bus_err_wb
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_load, is_store, misalign, aligned_op, timeout_hit;
  logic [XLEN-1:0] load_res;

  assign opcode   = instr_mem[6:0];
  assign funct3   = instr_mem[14:12];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);

  // H/HU need halfword alignment, W needs word alignment; B/BU never misalign.
  assign misalign   = (is_load || is_store) &&
                      (((funct3[1:0] == 2'b01) && alu_mem[0]) ||
                       ((funct3 == F3_W) && (alu_mem[1:0] != 2'b00)));
  assign aligned_op = (is_load || is_store) && !misalign;

  assign timeout_hit = (state == WAIT) && !dmem_ack && (cnt == CNT_LAST);

  assign forward_mem = alu_mem;
  assign dmem_addr   = {alu_mem[XLEN-1:2], 2'b00};
  assign dmem_we     = is_store;
  assign dmem_req    = !rst && ((state == WAIT) || aligned_op);
  assign stall_mem   = !rst && (((state == IDLE) && aligned_op && !dmem_ack) ||
                                ((state == WAIT) && !dmem_ack && !timeout_hit));

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = rs2_mem;
    case (funct3[1:0])
      2'b00: begin
        dmem_be    = 4'b0001 << alu_mem[1:0];
        dmem_wdata = {4{rs2_mem[7:0]}};
      end
      2'b01: begin
        dmem_be    = 4'b0011 << alu_mem[1:0];
        dmem_wdata = {2{rs2_mem[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = rs2_mem;
      end
    endcase
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .dmem_rdata (dmem_rdata),
    .addr       (alu_mem[1:0]),
    .funct3     (funct3),
    .result     (load_res)
  );

  // MEM/WB boundary and access FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pc_wb       <= '0;
      result_wb   <= '0;
      instr_wb    <= XLEN'(NOP_INSTR);
      rd_addr_wb  <= '0;
      misalign_wb <= 1'b0;
      bus_err_wb  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (aligned_op && !dmem_ack) begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: if (dmem_ack || timeout_hit) state <= IDLE;
              else                          cnt   <= cnt + 1'b1;
        default: state <= IDLE;
      endcase

      pc_wb <= pc_mem;
      if (stall_mem) begin
        result_wb   <= '0;
        instr_wb    <= XLEN'(NOP_INSTR);
        rd_addr_wb  <= '0;
        misalign_wb <= 1'b0;
        bus_err_wb  <= 1'b0;
      end else begin
        instr_wb    <= instr_mem;
        misalign_wb <= misalign;
        bus_err_wb  <= timeout_hit;
        if (misalign || timeout_hit) begin
          result_wb  <= '0;
          rd_addr_wb <= '0;
        end else if (is_load) begin
          result_wb  <= load_res;
          rd_addr_wb <= rd_addr_mem;
        end else if (is_store) begin
          result_wb  <= alu_mem;
          rd_addr_wb <= '0;
        end else begin
          result_wb  <= alu_mem;
          rd_addr_wb <= rd_addr_mem;
        end
      end
    end
  end

endmodule
